// File: rtl/flight_game_ctrl.sv
// Per-frame scheduler for the plane game: steps plane, mountain and lava positions once per
// frame tick, sequences erase/draw requests to the draw engine, and tracks play state and score.
module flight_game_ctrl #(
   parameter logic [9:0] PLANE_Y0    = 10'd120,
   parameter logic [9:0] PLANE_STEP  = 10'd4,
   parameter logic [9:0] Y_MIN       = 10'd8,
   parameter logic [9:0] Y_MAX       = 10'd232,
   parameter logic [9:0] SCROLL_STEP = 10'd2,
   parameter logic [9:0] X_WRAP      = 10'd320,
   parameter logic [9:0] M1_X0       = 10'd320,
   parameter logic [9:0] M2_X0       = 10'd480,
   parameter logic [9:0] LAVA_X0     = 10'd400
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        frame_tick,
   input  logic        start,
   input  logic        up,
   input  logic        down,
   input  logic        crash,
   input  logic        draw_ack,
   output logic [9:0]  plane_y,
   output logic [9:0]  mountain1_x,
   output logic [9:0]  mountain2_x,
   output logic [9:0]  lava_x,
   output logic        draw_req,
   output logic        draw_erase,
   output logic        playing,
   output logic        game_over,
   output logic [15:0] score
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_ERASE,
      S_UPDATE,
      S_CHECK,
      S_DRAW,
      S_OVER
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  plane_y_q, plane_y_d;
   logic [9:0]  m1_q, m1_d;
   logic [9:0]  m2_q, m2_d;
   logic [9:0]  lava_q, lava_d;
   logic [15:0] score_q, score_d;
   logic        crash_q, crash_d;
   logic        m1_wrap, m2_wrap;

   function automatic logic [9:0] scroll_x(input logic [9:0] x);
      return (x <= SCROLL_STEP) ? X_WRAP : x - SCROLL_STEP;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] s, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, s} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   assign m1_wrap = (m1_q <= SCROLL_STEP);
   assign m2_wrap = (m2_q <= SCROLL_STEP);

   always_comb begin
      state_d   = state_q;
      plane_y_d = plane_y_q;
      m1_d      = m1_q;
      m2_d      = m2_q;
      lava_d    = lava_q;
      score_d   = score_q;
      crash_d   = crash_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_WAIT_FRAME;
         end
         S_WAIT_FRAME: begin
            if (frame_tick) state_d = S_ERASE;
         end
         S_ERASE: begin
            if (draw_ack) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            if (up && !down)
               plane_y_d = (plane_y_q < Y_MIN + PLANE_STEP) ? Y_MIN : plane_y_q - PLANE_STEP;
            else if (down && !up)
               plane_y_d = (plane_y_q > Y_MAX - PLANE_STEP) ? Y_MAX : plane_y_q + PLANE_STEP;
            m1_d    = scroll_x(m1_q);
            m2_d    = scroll_x(m2_q);
            lava_d  = scroll_x(lava_q);
            // only mountain wraps are worth points; lava just recycles
            score_d = sat_add(score_q, {1'b0, m1_wrap} + {1'b0, m2_wrap});
            state_d = S_CHECK;
         end
         S_CHECK: begin
            // positions have been stable for a full cycle, so the checker output is valid
            crash_d = crash;
            state_d = S_DRAW;
         end
         S_DRAW: begin
            if (draw_ack) state_d = crash_q ? S_OVER : S_WAIT_FRAME;
         end
         S_OVER: begin
            if (start) begin
               plane_y_d = PLANE_Y0;
               m1_d      = M1_X0;
               m2_d      = M2_X0;
               lava_d    = LAVA_X0;
               score_d   = 16'd0;
               crash_d   = 1'b0;
               state_d   = S_WAIT_FRAME;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         plane_y_q <= PLANE_Y0;
         m1_q      <= M1_X0;
         m2_q      <= M2_X0;
         lava_q    <= LAVA_X0;
         score_q   <= 16'd0;
         crash_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         plane_y_q <= plane_y_d;
         m1_q      <= m1_d;
         m2_q      <= m2_d;
         lava_q    <= lava_d;
         score_q   <= score_d;
         crash_q   <= crash_d;
      end
   end

   // Decoded straight from the state register so reset drops a pending request at once.
   assign draw_req    = (state_q == S_ERASE) || (state_q == S_DRAW);
   assign draw_erase  = (state_q == S_ERASE);
   assign playing     = (state_q == S_WAIT_FRAME) || (state_q == S_ERASE) ||
                        (state_q == S_UPDATE) || (state_q == S_CHECK) || (state_q == S_DRAW);
   assign game_over   = (state_q == S_OVER);
   assign plane_y     = plane_y_q;
   assign mountain1_x = m1_q;
   assign mountain2_x = m2_q;
   assign lava_x      = lava_q;
   assign score       = score_q;

endmodule

// File: doc/flight_game_ctrl.md
Name: flight_game_ctrl

Overview:
Per-frame scheduler for the plane game. It owns the plane, mountain and lava positions and steps them once per frame tick. It sequences erase/draw requests to the VGA draw engine and samples the combinational crash result from the collision checker. It also holds the play/game-over state and the score.

Parameters:
PLANE_Y0, 10'd120, plane y after init
PLANE_STEP, 10'd4, plane y change per frame
Y_MIN, 10'd8, lowest legal plane y
Y_MAX, 10'd232, highest legal plane y
SCROLL_STEP, 10'd2, leftward scroll per frame for mountains and lava
X_WRAP, 10'd320, x an object reloads to when it leaves the left edge
M1_X0, 10'd320, mountain1 x after init
M2_X0, 10'd480, mountain2 x after init
LAVA_X0, 10'd400, lava x after init

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous reset, active low
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle pulse: begin or restart a game
up  in  1  level: move plane up (y decreases)
down  in  1  level: move plane down (y increases)
crash  in  1  combinational collision result computed from this block's position outputs
draw_ack  in  1  draw engine has finished the current request
plane_y  out  10  plane top y
mountain1_x  out  10  mountain1 left x
mountain2_x  out  10  mountain2 left x
lava_x  out  10  lava left x
draw_req  out  1  request to the draw engine to render all objects
draw_erase  out  1  1 = erase (background colour), 0 = draw; only meaningful while draw_req=1
playing  out  1  1 while a game is running
game_over  out  1  1 in OVER state
score  out  16  count of mountain wraps in the current game

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; plane_y=PLANE_Y0; mountain1_x=M1_X0; mountain2_x=M2_X0; lava_x=LAVA_X0; draw_req=0; draw_erase=0; playing=0; game_over=0; score=0.
- States are IDLE, WAIT_FRAME, ERASE, UPDATE, CHECK, DRAW, OVER.
- IDLE: on start, go to WAIT_FRAME with playing=1.
- WAIT_FRAME: on frame_tick, go to ERASE. frame_tick seen in any other state is ignored; no queuing.
- ERASE:
  - Assert draw_req=1 and draw_erase=1.
  - When draw_ack=1 is sampled: drop draw_req on the next edge and go to UPDATE.
- UPDATE (exactly one cycle), positions update together:
  - up and not down: plane_y = (plane_y < Y_MIN+PLANE_STEP) ? Y_MIN : plane_y-PLANE_STEP.
  - down and not up: plane_y = (plane_y > Y_MAX-PLANE_STEP) ? Y_MAX : plane_y+PLANE_STEP.
  - Both or neither pressed: plane_y is unchanged.
  - Each of mountain1_x, mountain2_x, lava_x: if x <= SCROLL_STEP then x = X_WRAP, else x = x-SCROLL_STEP.
  - score += 1 for each mountain that wraps this cycle (+2 if both wrap). score saturates at 16'hFFFF. Lava wraps do not score.
- CHECK (one cycle, after the new positions have settled through the checker):
  - Latch crash into an internal flag.
  - Go to DRAW.
- DRAW:
  - Assert draw_req=1 and draw_erase=0.
  - On draw_ack: go to OVER if the flag is set, else go to WAIT_FRAME.
- OVER: game_over=1, playing=0, positions and score held.
  - On start: reload all positions, clear score and flag, set game_over=0 and playing=1, go to WAIT_FRAME.
- Handshake rules:
  - draw_req rises only on a state entry.
  - draw_req and draw_erase stay stable until draw_ack is sampled high.
  - draw_ack while draw_req=0 is ignored.
  - draw_ack in the same cycle draw_req rises counts. Minimum request width is 1 cycle.
- start in any state other than IDLE or OVER is ignored.
- The crash input is ignored everywhere except CHECK.
- Async reset mid-handshake drops draw_req immediately. No partial-update state survives reset.
- Latency from frame_tick to first draw_req: 1 cycle. With ack tied high, a full frame takes 5 cycles, tick to return to WAIT_FRAME.

Test Plan:
- Reset release, then start pulse, then frame_tick, with draw_ack tied high, up=down=0 → draw_req high with draw_erase=1 one cycle after the tick. After UPDATE: mountain1_x=318, mountain2_x=478, lava_x=398, plane_y=120, score=0.
- Hold up for 30 frames from plane_y=120 → plane_y steps 116, 112 … and clamps at 8; it never underflows. Hold down → clamps at 232. Press up and down together → y unchanged.
- Force mountain1_x to 2 (run 159 frames from the start values) → the next UPDATE sets mountain1_x=320 and score=1. When mountain1 and mountain2 wrap in the same frame, score increments by 2.
- crash=1 only during CHECK → DRAW completes (draw_erase=0), then game_over=1 and playing=0. Further frame_ticks produce no draw_req. crash=1 outside CHECK has no effect.
- Delay draw_ack by 7 cycles in ERASE → draw_req and draw_erase stay constant for 7 cycles, and a frame_tick during the wait is dropped (exactly one UPDATE occurs).
- Start pulse in OVER → positions become 120/320/480/400, score=0, game_over=0. Assert resetn low during DRAW → all outputs return to reset values asynchronously.
